// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. It consumes a 16-bit BCD word (thousands..ones) and
// shows nibbles A-F as hex glyphs, because over-range values arrive as raw hex.
// It scans one anode per slot of DIV = CLK_HZ / REFRESH_HZ clocks.
//
// Optional build macro GHOST_GUARD_EN: when it is defined, all anodes are held
// off for the first GUARD clocks of every slot to suppress ghosting.
//
// Parameter constraints: DIV >= 2 and GUARD < DIV.

`timescale 1ns/1ps

module seven_seg_scanner #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned GUARD      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] BCDcode,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CW  = $clog2(DIV);

    localparam logic [CW-1:0] CntMax   = CW'(DIV - 1);
    localparam logic [CW-1:0] GuardCnt = CW'(GUARD);

`ifdef GHOST_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    localparam logic [6:0] SegBlank = 7'h7F;

    // Scan state
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   shd_q, shd_d;

    // Registered outputs
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic       slot_end;
    logic [3:0] nib;
    logic       blank;
    logic       guard_active;

    // Hex digit to segment pattern, active low, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        s = SegBlank;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt_q == CntMax);

    // Slot counter, digit index and end-of-scan shadow load.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        dig_d = dig_q;
        shd_d = shd_q;
        if (slot_end) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
            // Sampling only after the thousands slot keeps each scan coherent.
            if (dig_q == 2'd3) begin
                shd_d = BCDcode;
            end
        end
    end

    // Select the current nibble and decide whether it is a leading zero.
    always_comb begin
        nib   = shd_q[3:0];
        blank = 1'b0;
        unique case (dig_q)
            2'd0: begin
                nib   = shd_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = shd_q[7:4];
                blank = (shd_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = shd_q[11:8];
                blank = (shd_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib   = shd_q[15:12];
                blank = (shd_q[15:12] == 4'h0);
            end
            default: begin
                nib   = shd_q[3:0];
                blank = 1'b0;
            end
        endcase
    end

    // Guard window only exists when the ghost guard is built in.
    assign guard_active = GuardEn && (cnt_q < GuardCnt);

    // Next output values; a blanked digit keeps its anode so slot timing stays uniform.
    always_comb begin
        an_d  = ~(4'b0001 << dig_q);
        seg_d = hex_to_seg(nib);
        dp_d  = 1'b1;
        if (blank_lz && blank) begin
            seg_d = SegBlank;
        end
        if (guard_active) begin
            an_d = 4'b1111;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            dig_q <= 2'd0;
            shd_q <= 16'h0000;
            an_q  <= 4'b1111;
            seg_q <= SegBlank;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            shd_q <= shd_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with DIV = 4 (16-clock scan).
// Expected display records are queued as each clock edge is driven and
// compared at the following falling edge.

`timescale 1ns/1ps

module tb_seven_seg_scanner;

    localparam int Div = 4;
`ifdef GHOST_GUARD_EN
    localparam int GuardCyc = 1;
`else
    localparam int GuardCyc = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] BCDcode = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .CLK_HZ    (40),
        .REFRESH_HZ(10),
        .GUARD     (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .BCDcode (BCDcode),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    // Glyphs packed as {thousands, hundreds, tens, ones}.
    typedef struct {
        logic            blank;
        logic [15:0]     bcd;
        logic [3:0][6:0] g;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard checker
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                n_fail++;
                $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         e.name, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected end before time limit");
        $fatal(1, "time limit");
    end

    // One clock edge; queue the display expected right after it.
    task automatic step(input bit chk, input string name, input logic [3:0] e_an,
                        input logic [6:0] e_seg);
        exp_t e;
        @(posedge clk);
        #1;
        if (chk) begin
            e.name = name;
            e.an   = e_an;
            e.seg  = e_seg;
            e.dp   = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic slot(input bit chk, input string tag, input int s, input logic [6:0] g);
        logic [3:0] a;
        for (int c = 0; c < Div; c++) begin
            a = ~(4'b0001 << s);
            if (c < GuardCyc) a = 4'b1111;
            step(chk, $sformatf("%s d%0d c%0d", tag, s, c), a, g);
        end
    endtask

    task automatic scan(input bit chk, input string tag, input logic [3:0][6:0] g);
        for (int s = 0; s < 4; s++) begin
            slot(chk, tag, s, g[s]);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{1'b1, 16'h0012, {7'h7F, 7'h7F, 7'h79, 7'h24}};
        vecs[2] = '{1'b1, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{1'b1, 16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[4] = '{1'b0, 16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{1'b1, 16'h0105, {7'h7F, 7'h79, 7'h40, 7'h12}};
        vecs[6] = '{1'b0, 16'h9876, {7'h10, 7'h00, 7'h78, 7'h02}};
        vecs[7] = '{1'b1, 16'h00E0, {7'h7F, 7'h7F, 7'h06, 7'h40}};
        vecs[8] = '{1'b0, 16'hF5A0, {7'h0E, 7'h12, 7'h08, 7'h40}};
        vecs[9] = '{1'b1, 16'h1000, {7'h79, 7'h40, 7'h40, 7'h40}};

        // Reset held for three edges, then the first scan shows an empty shadow.
        reset    = 1'b1;
        blank_lz = 1'b0;
        BCDcode  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $sformatf("in reset %0d", i), 4'b1111, 7'h7F);
        end
        reset   = 1'b0;
        BCDcode = 16'h1234;
        scan(1'b1, "post reset", {7'h40, 7'h40, 7'h40, 7'h40});

        // Table vectors: one settling scan, then one checked scan.
        for (int v = 0; v < 10; v++) begin
            blank_lz = vecs[v].blank;
            BCDcode  = vecs[v].bcd;
            scan(1'b0, "settle", vecs[v].g);
            scan(1'b1, $sformatf("vec%0d %h", v, vecs[v].bcd), vecs[v].g);
        end

        // Tear-free update: change the input during the tens slot.
        blank_lz = 1'b0;
        BCDcode  = 16'h1234;
        scan(1'b0, "tear settle", {7'h79, 7'h24, 7'h30, 7'h19});
        scan(1'b1, "tear before", {7'h79, 7'h24, 7'h30, 7'h19});
        slot(1'b1, "tear old", 0, 7'h19);
        BCDcode = 16'h5678;
        slot(1'b1, "tear old", 1, 7'h30);
        slot(1'b1, "tear old", 2, 7'h24);
        slot(1'b1, "tear old", 3, 7'h79);
        scan(1'b1, "tear new", {7'h12, 7'h02, 7'h78, 7'h00});

        // One-cycle reset pulse in the hundreds slot.
        slot(1'b1, "pre pulse", 0, 7'h00);
        slot(1'b1, "pre pulse", 1, 7'h78);
        step(1'b1, "pre pulse d2 c0", (GuardCyc > 0) ? 4'b1111 : 4'b1011, 7'h02);
        reset = 1'b1;
        step(1'b1, "reset pulse", 4'b1111, 7'h7F);
        reset   = 1'b0;
        BCDcode = 16'h0042;
        scan(1'b1, "restart", {7'h40, 7'h40, 7'h40, 7'h40});
        scan(1'b1, "reload", {7'h40, 7'h40, 7'h19, 7'h24});

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending records, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
